halfband_output_fifo: RTL and testbench

- Downstream neighbour of the polyphase halfband decimator.
- Absorbs its single-cycle valid_out/data_out result pulses, which arrive at a decimated, bursty rate.
- Re-presents results on a valid/ready stream so a back-pressuring consumer (next decimation stage or output serializer) never loses samples silently.
- Adds occupancy reporting, almost-full warning and sticky overflow detection.

---
 rtl/halfband_output_fifo.sv | 102 ++++++++++
 tb/tb_halfband_output_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/halfband_output_fifo.sv
// halfband_output_fifo
//   Output buffer behind the polyphase halfband decimator. The decimator's
//   single-cycle valid/data pulses are captured here. They are then offered
//   on a show-ahead valid/ready stream, so a stalling consumer never silently
//   loses samples. The block also reports occupancy, an almost-full warning
//   and a sticky overflow flag.
//
//   Build option: define HB_OUTFIFO_DROP_CNT_EN to build the saturating
//   8-bit dropped-sample counter. When it is undefined, drop_count is tied
//   to zero.
//
// Ports
//   clk          : single clock
//   reset        : asynchronous, active-low reset
//   in_valid     : new sample pulse from the decimator (valid_out)
//   in_data      : sample word from the decimator (data_out)
//   out_valid    : head entry present on out_data
//   out_ready    : consumer takes the head entry this cycle
//   out_data     : head-of-queue sample (show-ahead)
//   count        : occupancy, 0..DEPTH
//   almost_full  : count >= ALMOST_FULL_LEVEL
//   overflow     : sticky, set when a sample was dropped
//   drop_count   : saturating count of dropped samples (0 unless enabled)

module halfband_output_fifo #(
    parameter int SAMPLE_WIDTH      = 6,
    parameter int DEPTH             = 8,
    parameter int ALMOST_FULL_LEVEL = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [SAMPLE_WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SAMPLE_WIDTH-1:0] out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic                    overflow,
    output logic [7:0]              drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LEVEL);

    logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // Full/empty come from count, so the pointers may wrap freely.
    assign full        = (count == FULL_LVL);
    assign out_valid   = (count != '0);
    assign out_data    = mem[rd_ptr];
    assign almost_full = (count >= AF_LVL);

    // A pop in the same cycle frees the slot, so a push into a full
    // queue is still accepted when the consumer takes the head.
    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    // Storage holds no reset. Its contents are meaningless until count says otherwise.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef HB_OUTFIFO_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_count <= 8'd0;
        else if (drop && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_halfband_output_fifo.sv
// Self-checking bench for halfband_output_fifo.
// A queue model keeps the expected FIFO contents. Entries are pushed when
// stimulus is driven and popped when the consumer takes the head. Inputs
// change on the falling edge, and outputs are sampled on the falling edge.

module tb_halfband_output_fifo;

    localparam int W   = 6;
    localparam int D   = 8;
    localparam int AFL = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [3:0]   count;
    logic         almost_full;
    logic         overflow;
    logic [7:0]   drop_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    bit           exp_ovf;
    int           exp_drops;

    halfband_output_fifo #(
        .SAMPLE_WIDTH      (W),
        .DEPTH             (D),
        .ALMOST_FULL_LEVEL (AFL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_dc();
`ifdef HB_OUTFIFO_DROP_CNT_EN
        return (exp_drops > 255) ? 8'd255 : 8'(exp_drops);
`else
        return 8'd0;
`endif
    endfunction

    // Drive one cycle of stimulus and update the model. This task is
    // entered on a falling edge and returns on the next falling edge.
    task automatic apply(input bit v, input logic [W-1:0] d, input bit r);
        bit pop;
        bit full;
        pop  = (exp_q.size() != 0) && r;
        full = (exp_q.size() == D);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (pop) exp_q.delete(0);
        if (v) begin
            if (!full || pop) exp_q.push_back(d);
            else begin
                exp_ovf = 1'b1;
                exp_drops++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_drops = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_init_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_init_count: got %0d expected 0", count); end
        // Fill past full so that every sticky state is set before reset.
        for (int i = 0; i < 9; i++) apply(1'b1, 6'(i + 3), 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rst_pre_ovf: got %0b expected 1", overflow); end
        reset = 1'b0;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_async_count: got %0d expected 0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_async_ovf: got %0b expected 0", overflow); end
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL rst_async_drops: got %0d expected 0", drop_count); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rst_async_af: got %0b expected 0", almost_full); end
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_drops = 0;
        @(negedge clk);
        reset = 1'b1;
        // The first sample after release must be the first one out.
        apply(1'b1, 6'h2C, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 6'h2C) begin n_err++; $display("FAIL rst_first_after: got %0b/%0h expected 1/2c", out_valid, out_data); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL rst_first_count: got %0d expected 1", count); end
    endtask

    task automatic test_basic();
        logic [W-1:0] vals [3];
        vals = '{6'h05, 6'h2A, 6'h3F};
        do_reset();
        for (int i = 0; i < 3; i++) apply(1'b1, vals[i], 1'b0);
        apply(1'b0, '0, 1'b0);
        n_cmp++; if (count !== 4'(exp_q.size()) || count !== 4'd3) begin n_err++; $display("FAIL basic_count: got %0d expected 3", count); end
        n_cmp++; if (out_data !== vals[0]) begin n_err++; $display("FAIL basic_hold: got %0h expected %0h", out_data, vals[0]); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin n_err++; $display("FAIL basic_drain%0d: got %0b/%0h expected 1/%0h", i, out_valid, out_data, vals[i]); end
            apply(1'b0, '0, 1'b1);
        end
        n_cmp++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL basic_empty: got %0b/%0d expected 0/0", out_valid, count); end
        // A ready signal while the FIFO is empty must not underflow the count.
        apply(1'b0, '0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL basic_underflow: got %0b/%0d expected 0/0", out_valid, count); end
    endtask

    task automatic test_full_drop();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            apply(1'b1, 6'(i), 1'b0);
            n_cmp++; if (count !== 4'(i)) begin n_err++; $display("FAIL fill_count%0d: got %0d expected %0d", i, count, i); end
            n_cmp++; if (almost_full !== (i >= AFL)) begin n_err++; $display("FAIL fill_af%0d: got %0b expected %0b", i, almost_full, (i >= AFL)); end
            n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf%0d: got %0b expected 0", i, overflow); end
        end
        apply(1'b1, 6'h09, 1'b0);
        n_cmp++; if (overflow !== exp_ovf || overflow !== 1'b1) begin n_err++; $display("FAIL drop_ovf: got %0b expected 1", overflow); end
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL drop_count_occ: got %0d expected 8", count); end
        n_cmp++; if (drop_count !== exp_dc()) begin n_err++; $display("FAIL drop_cnt: got %0d expected %0d", drop_count, exp_dc()); end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 6'(i)) begin n_err++; $display("FAIL drop_drain%0d: got %0b/%0h expected 1/%0h", i, out_valid, out_data, i); end
            apply(1'b0, '0, 1'b1);
        end
        n_cmp++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin n_err++; $display("FAIL drop_end: got %0b/%0b expected 0/1", out_valid, overflow); end
    endtask

    task automatic test_full_pushpop();
        logic [W-1:0] last;
        last = '0;
        do_reset();
        for (int i = 0; i < 8; i++) apply(1'b1, 6'(8'h21 + i), 1'b0);
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL pp_full: got %0d expected 8", count); end
        apply(1'b1, 6'h11, 1'b1);
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL pp_count: got %0d expected 8", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf: got %0b expected 0", overflow); end
        n_cmp++; if (out_data !== 6'h22) begin n_err++; $display("FAIL pp_head: got %0h expected 22", out_data); end
        for (int g = 0; g < 20 && exp_q.size() != 0; g++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_err++; $display("FAIL pp_drain%0d: got %0b/%0h expected 1/%0h", g, out_valid, out_data, exp_q[0]); end
            last = out_data;
            apply(1'b0, '0, 1'b1);
        end
        n_cmp++; if (last !== 6'h11 || out_valid !== 1'b0) begin n_err++; $display("FAIL pp_last: got %0h/%0b expected 11/0", last, out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== 6'(i - 1)) begin n_err++; $display("FAIL b2b_data%0d: got %0b/%0h expected 1/%0h", i, out_valid, out_data, i - 1); end
            end
            n_cmp++; if (count > 4'd1 || count !== 4'(exp_q.size())) begin n_err++; $display("FAIL b2b_count%0d: got %0d expected %0d", i, count, exp_q.size()); end
            apply(1'b1, 6'(i), 1'b1);
        end
        n_cmp++; if (out_data !== 6'd19) begin n_err++; $display("FAIL b2b_tail: got %0h expected 13", out_data); end
        apply(1'b0, '0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %0b expected 0", out_valid); end
    endtask

    task automatic test_drop_sat();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, 6'(i), 1'b0);
            n_cmp++; if (drop_count !== exp_dc()) begin n_err++; $display("FAIL sat_cyc%0d: got %0d expected %0d", i, drop_count, exp_dc()); end
        end
`ifdef HB_OUTFIFO_DROP_CNT_EN
        n_cmp++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL sat_final: got %0d expected 255", drop_count); end
`else
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL sat_final: got %0d expected 0", drop_count); end
`endif
        n_cmp++; if (overflow !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL sat_state: got %0b/%0d expected 1/8", overflow, count); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_full_drop();
        test_full_pushpop();
        test_back_to_back();
        test_drop_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
